// File: rtl/fcs_tx_append_pkg.sv
// Shared types and CRC-32 constants for the FCS append path.
package fcs_tx_append_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PAD,
    ST_FCS
  } state_t;

  localparam logic [31:0] CRC_POLY          = 32'h04C11DB7;
  localparam logic [31:0] CRC_INITIAL_VALUE = 32'hFFFFFFFF;
  // Residue left after running the CRC over a frame plus its own FCS.
  localparam logic [31:0] CRC_REMAINDER     = 32'hC704DD7B;

endpackage

// File: rtl/fcs_tx_append_if.sv
// Byte stream with valid/ready handshake and end-of-frame marker.
interface fcs_tx_append_if;
  logic       valid;
  logic       ready;
  logic [7:0] data;
  logic       last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/fcs_tx_append_crc32_byte_step.sv
// One byte of IEEE 802.3 CRC-32, MSB-first, data folded into the top byte.
module crc32_byte_step
  import fcs_tx_append_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] next
);

  logic [31:0] c;

  always_comb begin
    c = crc ^ {data, 24'h000000};
    for (int i = 0; i < 8; i++) begin
      c = c[31] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
  end

  assign next = c;

endmodule

// File: rtl/fcs_tx_append.sv
// Pads frames to MIN_LEN and appends the CRC-32 FCS; 1-cycle latency in to out.
// Backpressure: single output register, input stalls when it is full or during pad/FCS.
module fcs_tx_append #(
  parameter int unsigned MIN_LEN           = 60,
  parameter logic [31:0] CRC_INITIAL_VALUE = fcs_tx_append_pkg::CRC_INITIAL_VALUE
) (
  input  logic                   clk,
  input  logic                   reset,
  fcs_tx_append_if.slave         in_s,
  fcs_tx_append_if.master        out_m,
  output logic [15:0]            frame_count
);
  import fcs_tx_append_pkg::*;

  state_t      state;
  logic [31:0] crc;
  logic [31:0] crc_next;
  logic [15:0] byte_count;
  logic [15:0] bc_inc;
  logic [1:0]  fcs_idx;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        free;
  logic        short_frame;
  logic        pad_done;
  logic [7:0]  step_data;
  logic [7:0]  fcs_byte;

  assign free        = !out_valid || out_m.ready;
  assign in_s.ready  = free && (state == ST_IDLE || state == ST_DATA);
  assign step_data   = (state == ST_PAD) ? 8'h00 : in_s.data;
  assign bc_inc      = (byte_count == 16'hFFFF) ? byte_count : byte_count + 16'd1;
  assign short_frame = (MIN_LEN != 0) && (({16'd0, byte_count} + 32'd1) < MIN_LEN);
  assign pad_done    = {16'd0, bc_inc} >= MIN_LEN;

  assign out_m.valid = out_valid;
  assign out_m.data  = out_data;
  assign out_m.last  = out_last;

  crc32_byte_step u_step (
    .crc  (crc),
    .data (step_data),
    .next (crc_next)
  );

  // FCS goes out most-significant byte first, inverted.
  always_comb begin
    fcs_byte = 8'h00;
    case (fcs_idx)
      2'd0:    fcs_byte = ~crc[31:24];
      2'd1:    fcs_byte = ~crc[23:16];
      2'd2:    fcs_byte = ~crc[15:8];
      default: fcs_byte = ~crc[7:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      crc         <= CRC_INITIAL_VALUE;
      byte_count  <= 16'd0;
      fcs_idx     <= 2'd0;
      out_valid   <= 1'b0;
      out_data    <= 8'h00;
      out_last    <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      if (out_valid && out_m.ready && out_last) begin
        frame_count <= frame_count + 16'd1;
      end
      if (free) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        case (state)
          ST_IDLE, ST_DATA: begin
            if (in_s.valid) begin
              out_valid  <= 1'b1;
              out_data   <= in_s.data;
              crc        <= crc_next;
              byte_count <= bc_inc;
              if (in_s.last) begin
                state <= short_frame ? ST_PAD : ST_FCS;
              end else begin
                state <= ST_DATA;
              end
            end
          end
          ST_PAD: begin
            out_valid  <= 1'b1;
            out_data   <= 8'h00;
            crc        <= crc_next;
            byte_count <= bc_inc;
            if (pad_done) begin
              state <= ST_FCS;
            end
          end
          ST_FCS: begin
            out_valid <= 1'b1;
            out_data  <= fcs_byte;
            fcs_idx   <= fcs_idx + 2'd1;
            if (fcs_idx == 2'd3) begin
              out_last   <= 1'b1;
              state      <= ST_IDLE;
              crc        <= CRC_INITIAL_VALUE;
              byte_count <= 16'd0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
